// File: rtl/riscv_ex_operand_stage.sv
// riscv_ex_operand_stage
//   ID/EX register ahead of the ALU. Holds one decoded instruction, selects
//   the ALU operands, forwards results from MEM/WB and stalls while a load
//   result in MEM is not yet available.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   valid_i / ready_o             upstream handshake (decoder)
//   pc_i, imm_i                   instruction PC and sign-extended immediate
//   rs1/rs2_addr_i, _data_i       source indices and register-file read data
//   a_sel_i, b_sel_i              operand selects (a: rs1/pc/0/0, b: rs2/imm/4/0)
//   alu_op_i, rd_addr_i           passed through to the ALU side
//   flush_i                       kill the held instruction
//   mem_*_i                       MEM-stage producer (mem_data_ok_i=0: load pending)
//   wb_*_i                        WB-stage register-file write port
//   valid_o / ready_i             downstream handshake (ALU)
//   alu_a_o, alu_b_o, alu_op_o    ALU operands and opcode
//   rd_addr_o, store_data_o       destination index, forwarded rs2 for stores
module riscv_ex_operand_stage #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [4:0]      rs1_addr_i,
   input  logic [4:0]      rs2_addr_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic [1:0]      a_sel_i,
   input  logic [1:0]      b_sel_i,
   input  logic [4:0]      alu_op_i,
   input  logic [4:0]      rd_addr_i,
   input  logic            flush_i,
   input  logic            mem_we_i,
   input  logic [4:0]      mem_rd_i,
   input  logic [XLEN-1:0] mem_data_i,
   input  logic            mem_data_ok_i,
   input  logic            wb_we_i,
   input  logic [4:0]      wb_rd_i,
   input  logic [XLEN-1:0] wb_data_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] alu_a_o,
   output logic [XLEN-1:0] alu_b_o,
   output logic [4:0]      alu_op_o,
   output logic [4:0]      rd_addr_o,
   output logic [XLEN-1:0] store_data_o
);

   logic            valid_q,    valid_d;
   logic [XLEN-1:0] pc_q,       pc_d;
   logic [XLEN-1:0] imm_q,      imm_d;
   logic [4:0]      rs1_addr_q, rs1_addr_d;
   logic [4:0]      rs2_addr_q, rs2_addr_d;
   logic [XLEN-1:0] rs1_data_q, rs1_data_d;
   logic [XLEN-1:0] rs2_data_q, rs2_data_d;
   logic [1:0]      a_sel_q,    a_sel_d;
   logic [1:0]      b_sel_q,    b_sel_d;
   logic [4:0]      op_q,       op_d;
   logic [4:0]      rd_q,       rd_d;

   logic            mem_hit1, mem_hit2, wb_hit1, wb_hit2;
   logic [XLEN-1:0] rs1_fwd, rs2_fwd;
   logic            hazard, accept;

   // Forwarding on the held entry; x0 never hits and always reads as zero.
   always_comb begin
      mem_hit1 = mem_we_i && (mem_rd_i == rs1_addr_q) && (rs1_addr_q != '0);
      mem_hit2 = mem_we_i && (mem_rd_i == rs2_addr_q) && (rs2_addr_q != '0);
      wb_hit1  = wb_we_i  && (wb_rd_i  == rs1_addr_q) && (rs1_addr_q != '0);
      wb_hit2  = wb_we_i  && (wb_rd_i  == rs2_addr_q) && (rs2_addr_q != '0);

      if (rs1_addr_q == '0) rs1_fwd = '0;
      else if (mem_hit1)    rs1_fwd = mem_data_i;
      else if (wb_hit1)     rs1_fwd = wb_data_i;
      else                  rs1_fwd = rs1_data_q;

      if (rs2_addr_q == '0) rs2_fwd = '0;
      else if (mem_hit2)    rs2_fwd = mem_data_i;
      else if (wb_hit2)     rs2_fwd = wb_data_i;
      else                  rs2_fwd = rs2_data_q;
   end

   // rs2 always feeds store_data_o, so any pending-load hit on rs2 stalls;
   // rs1 only stalls when it is actually selected onto operand a.
   always_comb begin
      hazard  = valid_q && !mem_data_ok_i &&
                ((mem_hit1 && (a_sel_q == 2'd0)) || mem_hit2);
      valid_o = valid_q && !hazard;
      ready_o = !valid_q || (ready_i && !hazard);
      accept  = valid_i && ready_o;
   end

   always_comb begin
      case (a_sel_q)
         2'd0:    alu_a_o = rs1_fwd;
         2'd1:    alu_a_o = pc_q;
         default: alu_a_o = '0;
      endcase
      case (b_sel_q)
         2'd0:    alu_b_o = rs2_fwd;
         2'd1:    alu_b_o = imm_q;
         2'd2:    alu_b_o = XLEN'(4);
         default: alu_b_o = '0;
      endcase
      store_data_o = rs2_fwd;
      alu_op_o     = op_q;
      rd_addr_o    = rd_q;
   end

   always_comb begin
      valid_d    = valid_q;
      pc_d       = pc_q;
      imm_d      = imm_q;
      rs1_addr_d = rs1_addr_q;
      rs2_addr_d = rs2_addr_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      a_sel_d    = a_sel_q;
      b_sel_d    = b_sel_q;
      op_d       = op_q;
      rd_d       = rd_q;

      if (flush_i) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d    = 1'b1;
         pc_d       = pc_i;
         imm_d      = imm_i;
         rs1_addr_d = rs1_addr_i;
         rs2_addr_d = rs2_addr_i;
         // Register file is read before the WB write lands; bypass it here.
         rs1_data_d = (wb_we_i && wb_rd_i == rs1_addr_i && rs1_addr_i != '0) ? wb_data_i : rs1_data_i;
         rs2_data_d = (wb_we_i && wb_rd_i == rs2_addr_i && rs2_addr_i != '0) ? wb_data_i : rs2_data_i;
         a_sel_d    = a_sel_i;
         b_sel_d    = b_sel_i;
         op_d       = alu_op_i;
         rd_d       = rd_addr_i;
      end else if (valid_q) begin
         if (valid_o && ready_i) valid_d = 1'b0;
         // Capture WB writes so the value survives the producer retiring.
         if (wb_hit1) rs1_data_d = wb_data_i;
         if (wb_hit2) rs2_data_d = wb_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         imm_q      <= '0;
         rs1_addr_q <= '0;
         rs2_addr_q <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         a_sel_q    <= '0;
         b_sel_q    <= '0;
         op_q       <= '0;
         rd_q       <= '0;
      end else begin
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         imm_q      <= imm_d;
         rs1_addr_q <= rs1_addr_d;
         rs2_addr_q <= rs2_addr_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         a_sel_q    <= a_sel_d;
         b_sel_q    <= b_sel_d;
         op_q       <= op_d;
         rd_q       <= rd_d;
      end
   end

endmodule

// File: tb/tb_riscv_ex_operand_stage.sv
// Directed bench for riscv_ex_operand_stage: reset, issue, forwarding,
// load-use stall, hold capture, write-back bypass, flush and select decoding.
module tb_riscv_ex_operand_stage;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        valid_i, ready_o, flush_i, valid_o, ready_i;
   logic [31:0] pc_i, imm_i, rs1_data_i, rs2_data_i;
   logic [4:0]  rs1_addr_i, rs2_addr_i, alu_op_i, rd_addr_i;
   logic [1:0]  a_sel_i, b_sel_i;
   logic        mem_we_i, mem_data_ok_i, wb_we_i;
   logic [4:0]  mem_rd_i, wb_rd_i;
   logic [31:0] mem_data_i, wb_data_i;
   logic [31:0] alu_a_o, alu_b_o, store_data_o;
   logic [4:0]  alu_op_o, rd_addr_o;

   int n_cmp = 0;
   int n_err = 0;

   riscv_ex_operand_stage #(.XLEN(32)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .valid_i(valid_i), .ready_o(ready_o),
      .pc_i(pc_i), .imm_i(imm_i),
      .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
      .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .a_sel_i(a_sel_i), .b_sel_i(b_sel_i),
      .alu_op_i(alu_op_i), .rd_addr_i(rd_addr_i),
      .flush_i(flush_i),
      .mem_we_i(mem_we_i), .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i),
      .mem_data_ok_i(mem_data_ok_i),
      .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
      .valid_o(valid_o), .ready_i(ready_i),
      .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
      .rd_addr_o(rd_addr_o), .store_data_o(store_data_o)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached (got timeout, want finish)");
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1);
   end

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      valid_i = 0; flush_i = 0; pc_i = '0; imm_i = '0;
      rs1_addr_i = '0; rs2_addr_i = '0; rs1_data_i = '0; rs2_data_i = '0;
      a_sel_i = '0; b_sel_i = '0; alu_op_i = '0; rd_addr_i = '0;
      mem_we_i = 0; mem_rd_i = '0; mem_data_i = '0; mem_data_ok_i = 1;
      wb_we_i = 0; wb_rd_i = '0; wb_data_i = '0;
   endtask

   task automatic present(input logic [4:0] r1, input logic [31:0] d1,
                          input logic [4:0] r2, input logic [31:0] d2,
                          input logic [1:0] as, input logic [1:0] bs,
                          input logic [4:0] op, input logic [4:0] rd);
      valid_i = 1; rs1_addr_i = r1; rs1_data_i = d1; rs2_addr_i = r2; rs2_data_i = d2;
      a_sel_i = as; b_sel_i = bs; alu_op_i = op; rd_addr_i = rd;
   endtask

   task automatic test_reset();
      rst_ni = 0; ready_i = 0; idle();
      #12;
      n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_o); end
      n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready_o); end
      n_cmp++; if ({alu_a_o, alu_b_o, store_data_o} !== 96'h0) begin n_err++;
         $display("FAIL reset_data: got a=%h b=%h s=%h want 0", alu_a_o, alu_b_o, store_data_o); end
      n_cmp++; if ({alu_op_o, rd_addr_o} !== 10'h0) begin n_err++;
         $display("FAIL reset_op_rd: got op=%h rd=%h want 0", alu_op_o, rd_addr_o); end
      tick(); rst_ni = 1; tick();
   endtask

   task automatic test_basic_issue();
      ready_i = 1;
      present(5'd1, 32'd5, 5'd2, 32'd7, 2'd0, 2'd0, 5'd0, 5'd10);
      #1;
      n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b want 1", ready_o); end
      n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL basic_no_comb_valid: got %b want 0", valid_o); end
      tick(); idle();
      #1;
      n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", valid_o); end
      n_cmp++; if (alu_a_o !== 32'd5 || alu_b_o !== 32'd7) begin n_err++;
         $display("FAIL basic_operands: got a=%0d b=%0d want 5 7", alu_a_o, alu_b_o); end
      n_cmp++; if (rd_addr_o !== 5'd10 || store_data_o !== 32'd7) begin n_err++;
         $display("FAIL basic_rd_store: got rd=%0d s=%0d want 10 7", rd_addr_o, store_data_o); end
      tick();
      n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %b want 0", valid_o); end
   endtask

   task automatic test_back_to_back();
      ready_i = 1;
      for (int i = 0; i < 4; i++) begin
         present(5'd1, 32'd20 + 32'(i), 5'd2, 32'd40 + 32'(i), 2'd0, 2'd0, 5'(i + 1), 5'd3);
         #1;
         n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, ready_o); end
         tick();
         n_cmp++; if (valid_o !== 1'b1 || alu_a_o !== 32'd20 + 32'(i) || alu_op_o !== 5'(i + 1)) begin n_err++;
            $display("FAIL b2b_issue[%0d]: got v=%b a=%0d op=%0d want 1 %0d %0d", i, valid_o, alu_a_o, alu_op_o, 20 + i, i + 1); end
      end
      idle(); tick();
      n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", valid_o); end
   endtask

   task automatic test_forward_priority();
      ready_i = 0;
      present(5'd3, 32'h1, 5'd0, 32'h0, 2'd0, 2'd1, 5'd0, 5'd1);
      tick(); idle();
      mem_we_i = 1; mem_rd_i = 5'd3; mem_data_i = 32'hAAAA;
      wb_we_i = 1; wb_rd_i = 5'd3; wb_data_i = 32'hBBBB;
      #1;
      n_cmp++; if (alu_a_o !== 32'hAAAA) begin n_err++; $display("FAIL fwd_mem_prio: got %h want aaaa", alu_a_o); end
      mem_we_i = 0; #1;
      n_cmp++; if (alu_a_o !== 32'hBBBB) begin n_err++; $display("FAIL fwd_wb: got %h want bbbb", alu_a_o); end
      wb_we_i = 0; #1;
      n_cmp++; if (alu_a_o !== 32'h1) begin n_err++; $display("FAIL fwd_none: got %h want 1", alu_a_o); end
      ready_i = 1; tick();
      // x0 source carrying nonzero read data must still read as zero.
      ready_i = 0;
      present(5'd0, 32'h77, 5'd0, 32'h0, 2'd0, 2'd1, 5'd0, 5'd1);
      tick(); idle();
      mem_we_i = 1; mem_rd_i = 5'd0; mem_data_i = 32'h1234;
      wb_we_i = 1; wb_rd_i = 5'd0; wb_data_i = 32'h5678;
      #1;
      n_cmp++; if (alu_a_o !== 32'h0 || valid_o !== 1'b1) begin n_err++;
         $display("FAIL fwd_x0: got a=%h v=%b want 0 1", alu_a_o, valid_o); end
      idle(); ready_i = 1; tick();
   endtask

   task automatic test_load_use();
      ready_i = 1;
      present(5'd6, 32'h3, 5'd5, 32'h11, 2'd0, 2'd0, 5'd0, 5'd2);
      tick(); idle();
      mem_we_i = 1; mem_rd_i = 5'd5; mem_data_i = 32'hDEAD; mem_data_ok_i = 0;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_cmp++; if (valid_o !== 1'b0 || ready_o !== 1'b0) begin n_err++;
            $display("FAIL load_stall[%0d]: got v=%b r=%b want 0 0", c, valid_o, ready_o); end
         tick();
      end
      mem_data_ok_i = 1; mem_data_i = 32'h55; #1;
      n_cmp++; if (valid_o !== 1'b1 || alu_b_o !== 32'h55 || store_data_o !== 32'h55) begin n_err++;
         $display("FAIL load_release: got v=%b b=%h s=%h want 1 55 55", valid_o, alu_b_o, store_data_o); end
      n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL load_release_ready: got %b want 1", ready_o); end
      tick(); idle();
      // Pending load on a source not selected onto an operand: no stall.
      pc_i = 32'h200; imm_i = 32'h30;
      present(5'd5, 32'h9, 5'd7, 32'h8, 2'd1, 2'd1, 5'd0, 5'd2);
      tick(); idle();
      mem_we_i = 1; mem_rd_i = 5'd5; mem_data_i = 32'hDEAD; mem_data_ok_i = 0; #1;
      n_cmp++; if (valid_o !== 1'b1 || alu_a_o !== 32'h200 || alu_b_o !== 32'h30) begin n_err++;
         $display("FAIL load_unused: got v=%b a=%h b=%h want 1 200 30", valid_o, alu_a_o, alu_b_o); end
      tick(); idle();
   endtask

   task automatic test_hold_capture();
      ready_i = 0;
      present(5'd4, 32'd1, 5'd0, 32'd0, 2'd0, 2'd1, 5'd0, 5'd4);
      tick(); idle();
      wb_we_i = 1; wb_rd_i = 5'd4; wb_data_i = 32'd9;
      tick(); idle(); tick();
      ready_i = 1; #1;
      n_cmp++; if (alu_a_o !== 32'd9 || valid_o !== 1'b1) begin n_err++;
         $display("FAIL hold_capture: got a=%0d v=%b want 9 1", alu_a_o, valid_o); end
      tick();
      // Write-back bypass when WB writes the incoming source during accept.
      present(5'd0, 32'd0, 5'd8, 32'd3, 2'd2, 2'd0, 5'd0, 5'd4);
      wb_we_i = 1; wb_rd_i = 5'd8; wb_data_i = 32'h66;
      tick(); idle(); #1;
      n_cmp++; if (alu_b_o !== 32'h66) begin n_err++; $display("FAIL wb_bypass: got %h want 66", alu_b_o); end
      tick();
   endtask

   task automatic test_flush_and_selects();
      ready_i = 0;
      present(5'd1, 32'h1, 5'd2, 32'h2, 2'd0, 2'd0, 5'd0, 5'd1);
      tick();
      ready_i = 1; flush_i = 1;
      present(5'd3, 32'h3, 5'd4, 32'h4, 2'd0, 2'd0, 5'd0, 5'd2);
      #1;
      n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b want 1", ready_o); end
      tick(); idle(); #1;
      n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", valid_o); end
      ready_i = 0; pc_i = 32'h100;
      present(5'd1, 32'h9, 5'd2, 32'h9, 2'd1, 2'd2, 5'd5, 5'd9);
      tick(); idle(); #1;
      n_cmp++; if (alu_a_o !== 32'h100 || alu_b_o !== 32'd4 || alu_op_o !== 5'd5 || rd_addr_o !== 5'd9) begin n_err++;
         $display("FAIL sel_pc_4: got a=%h b=%h op=%0d rd=%0d want 100 4 5 9", alu_a_o, alu_b_o, alu_op_o, rd_addr_o); end
      ready_i = 1; tick();
      present(5'd1, 32'h9, 5'd2, 32'h9, 2'd3, 2'd3, 5'd0, 5'd9);
      tick(); idle(); #1;
      n_cmp++; if (alu_a_o !== 32'h0 || alu_b_o !== 32'h0 || store_data_o !== 32'h9) begin n_err++;
         $display("FAIL sel_zero: got a=%h b=%h s=%h want 0 0 9", alu_a_o, alu_b_o, store_data_o); end
      tick();
   endtask

   task automatic test_reset_mid();
      ready_i = 0;
      present(5'd1, 32'hF0, 5'd2, 32'hF1, 2'd0, 2'd0, 5'd7, 5'd7);
      tick(); idle(); #1;
      n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL midrst_pre: got %b want 1", valid_o); end
      rst_ni = 0; #1;
      n_cmp++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin n_err++;
         $display("FAIL midrst_handshake: got v=%b r=%b want 0 1", valid_o, ready_o); end
      n_cmp++; if ({alu_a_o, alu_b_o, store_data_o, alu_op_o, rd_addr_o} !== 106'h0) begin n_err++;
         $display("FAIL midrst_outputs: got a=%h b=%h s=%h op=%h rd=%h want 0", alu_a_o, alu_b_o, store_data_o, alu_op_o, rd_addr_o); end
      tick(); rst_ni = 1; tick();
      n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL midrst_discard: got %b want 0", valid_o); end
   endtask

   initial begin
      test_reset();
      test_basic_issue();
      test_back_to_back();
      test_forward_priority();
      test_load_use();
      test_hold_capture();
      test_flush_and_selects();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
